// File: rtl/add_serial.sv
// add_serial: digit-serial adder/subtractor. One DIGIT-wide slice of the
// operands is added per clock, LSB slice first, until the result completes.
//
// Ports:
//   clock      rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new operation. Ignored while busy.
//   op         00 a+b, 01 a+1, 10 a-b, 11 a
//   a, b       operands, captured when start is accepted
//   busy       operation in progress
//   done       one-cycle pulse, sum/carry_out just updated
//   sum        registered result
//   carry_out  carry out of the MSB. For a-b, 1 means no borrow.
//   ovf        signed overflow, present only when ADD_SERIAL_OVF_EN is defined
module add_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ADD_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [DIGIT-1:0] a_s;
  logic [DIGIT-1:0] b_s;
  logic [DIGIT-1:0] r_s;
  logic             c_s;
  logic             c_msb;
  logic             accept;
  logic             last;

  // Increment and pass-through reuse the adder with a zero B operand.
  always_comb begin
    b_eff   = '0;
    cin_eff = 1'b0;
    unique case (1'b1)
      op == 2'b00: begin
        b_eff   = b;
        cin_eff = 1'b0;
      end
      op == 2'b01: begin
        b_eff   = '0;
        cin_eff = 1'b1;
      end
      op == 2'b10: begin
        b_eff   = ~b;
        cin_eff = 1'b1;
      end
      default: begin
        b_eff   = '0;
        cin_eff = 1'b0;
      end
    endcase
  end

  // Operands shift right so the active slice is always at the bottom.
  assign a_s = a_q[DIGIT-1:0];
  assign b_s = b_q[DIGIT-1:0];

  assign {c_s, r_s} = {1'b0, a_s} + {1'b0, b_s} + {{DIGIT{1'b0}}, carry};

  // Carry into the top bit of the slice. Used only on the final slice.
  assign c_msb = r_s[DIGIT-1] ^ a_s[DIGIT-1] ^ b_s[DIGIT-1];

  // Result digits enter at the top. After N slices they are in place.
  assign part_nxt = (part >> DIGIT) | (WIDTH'(r_s) << (WIDTH - DIGIT));

  assign last   = (cnt == LAST);
  assign accept = start && (state != RUN);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      part      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b_eff;
      carry <= cin_eff;
      cnt   <= '0;
      part  <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      carry <= c_s;
      part  <= part_nxt;
      cnt   <= cnt + CW'(1);
      // Only the completed result is ever published.
      if (last) begin
        sum       <= part_nxt;
        carry_out <= c_s;
`ifdef ADD_SERIAL_OVF_EN
        ovf       <= c_msb ^ c_s;
`endif
      end
    end
  end

`ifndef ADD_SERIAL_OVF_EN
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: randomized self-checking bench for add_serial.
// Runs a DIGIT=4 and a DIGIT=16 instance against a plain arithmetic model.
module tb_add_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start1;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        busy1;
  logic        done1;
  logic [15:0] sum1;
  logic        carry1;
`ifdef ADD_SERIAL_OVF_EN
  logic        ovf;
  logic        ovf1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clock     (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef ADD_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  add_serial #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clock     (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (carry1)
`ifdef ADD_SERIAL_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  // Returns {ovf, carry, sum} from plain 17-bit arithmetic.
  function automatic logic [17:0] model(
    input logic [1:0]  o,
    input logic [15:0] x,
    input logic [15:0] y
  );
    logic [15:0] be;
    logic [16:0] t;
    logic        v;
    case (o)
      2'd0: t = {1'b0, x} + {1'b0, y};
      2'd1: t = {1'b0, x} + 17'd1;
      2'd2: t = {1'b0, x} + {1'b0, ~y} + 17'd1;
      default: t = {1'b0, x};
    endcase
    be = (o == 2'd0) ? y : (o == 2'd2) ? ~y : 16'h0000;
    v  = (x[15] == be[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  task automatic issue(input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, counting edges. junk=1 scribbles inputs during RUN.
  task automatic wait_done(output int lat, input bit junk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (junk) begin
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    op     = 2'd0;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, sum, carry_out} !== 19'd0) begin
      bad++;
      $display("FAIL reset got=%h exp=0", {busy, done, sum, carry_out});
    end
    total++;
    if ({busy1, done1, sum1, carry1} !== 19'd0) begin
      bad++;
      $display("FAIL reset1 got=%h exp=0", {busy1, done1, sum1, carry1});
    end
`ifdef ADD_SERIAL_OVF_EN
    total++;
    if ({ovf, ovf1} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ovf got=%b exp=00", {ovf, ovf1});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int bcnt;
    int lat;
    issue(2'd0, 16'h0000, 16'hFFFF);
    bcnt = busy ? 1 : 0;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL add_lat got=%0d exp=4", lat);
    end
    total++;
    if (bcnt !== 4) begin
      bad++;
      $display("FAIL add_busy got=%0d exp=4", bcnt);
    end
    total++;
    if ({carry_out, sum} !== 17'h0FFFF) begin
      bad++;
      $display("FAIL add_sum got=%h exp=0ffff", {carry_out, sum});
    end
    @(posedge clk);
    #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL add_pulse got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'd0, 16'hFFFF, 16'hFFFF);
    wait_done(lat, 1'b0);
    total++;
    if ({carry_out, sum} !== 17'h1FFFE || lat !== 4) begin
      bad++;
      $display("FAIL b2b_first got=%h lat=%0d exp=1fffe lat=4",
               {carry_out, sum}, lat);
    end
    op    = 2'd0;
    a     = 16'hAAAA;
    b     = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_accept got=%b exp=10", {busy, done});
    end
    total++;
    if (sum !== 16'hFFFE) begin
      bad++;
      $display("FAIL b2b_hold got=%h exp=fffe", sum);
    end
    wait_done(lat, 1'b0);
    total++;
    if ({carry_out, sum} !== 17'h0FFFF || lat !== 4) begin
      bad++;
      $display("FAIL b2b_second got=%h lat=%0d exp=0ffff lat=4",
               {carry_out, sum}, lat);
    end
  endtask

  task automatic test_inc_sub();
    int lat;
    issue(2'd1, 16'hFFFF, 16'h1234);
    wait_done(lat, 1'b0);
    total++;
    if ({carry_out, sum} !== 17'h10000 || lat !== 4) begin
      bad++;
      $display("FAIL inc got=%h lat=%0d exp=10000 lat=4",
               {carry_out, sum}, lat);
    end
    issue(2'd2, 16'h0000, 16'h0001);
    wait_done(lat, 1'b0);
    total++;
    if ({carry_out, sum} !== 17'h0FFFF || lat !== 4) begin
      bad++;
      $display("FAIL sub got=%h lat=%0d exp=0ffff lat=4",
               {carry_out, sum}, lat);
    end
  endtask

  task automatic test_abort();
    bit seen;
    int lat;
    issue(2'd0, 16'h1234, 16'h1111);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, carry_out} !== 19'd0) begin
      bad++;
      $display("FAIL abort_clear got=%h exp=0", {busy, done, sum, carry_out});
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet got=%b exp=0", seen);
    end
    issue(2'd0, 16'h0003, 16'h0004);
    wait_done(lat, 1'b0);
    total++;
    if ({carry_out, sum} !== 17'h00007 || lat !== 4) begin
      bad++;
      $display("FAIL abort_next got=%h lat=%0d exp=00007 lat=4",
               {carry_out, sum}, lat);
    end
  endtask

  task automatic test_ovf();
`ifdef ADD_SERIAL_OVF_EN
    int lat;
    issue(2'd0, 16'h7FFF, 16'h0001);
    wait_done(lat, 1'b0);
    total++;
    if ({ovf, sum} !== 17'h18000) begin
      bad++;
      $display("FAIL ovf_add got=%h exp=18000", {ovf, sum});
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [17:0] e;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 8 == 0) x = 16'hFFFF;
      if (i % 8 == 1) y = 16'h8000;
      e = model(o, x, y);
      issue(o, x, y);
      wait_done(lat, 1'b1);
      total++;
      if ({carry_out, sum} !== e[16:0] || lat !== 4) begin
        bad++;
        $display("FAIL rand op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=4",
                 o, x, y, {carry_out, sum}, lat, e[16:0]);
      end
`ifdef ADD_SERIAL_OVF_EN
      total++;
      if (ovf !== e[17]) begin
        bad++;
        $display("FAIL rand_ovf got=%b exp=%b", ovf, e[17]);
      end
`endif
    end
  endtask

  task automatic test_n1();
    logic [1:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [17:0] e;
    for (int i = 0; i < 12; i++) begin
      o = (i == 0) ? 2'd2 : 2'($urandom);
      x = (i == 0) ? 16'h8000 : 16'($urandom);
      y = (i == 0) ? 16'h0001 : 16'($urandom);
      e = model(o, x, y);
      @(negedge clk);
      op     = o;
      a      = x;
      b      = y;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      a      = ~x;
      @(posedge clk);
      #1;
      total++;
      if ({done1, carry1, sum1} !== {1'b1, e[16:0]}) begin
        bad++;
        $display("FAIL n1 op=%0d a=%h b=%h got=%h exp=%h",
                 o, x, y, {done1, carry1, sum1}, {1'b1, e[16:0]});
      end
`ifdef ADD_SERIAL_OVF_EN
      total++;
      if (ovf1 !== e[17]) begin
        bad++;
        $display("FAIL n1_ovf got=%b exp=%b", ovf1, e[17]);
      end
`endif
      @(posedge clk);
      #1;
      total++;
      if (done1 !== 1'b0) begin
        bad++;
        $display("FAIL n1_pulse got=%b exp=0", done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_inc_sub();
    test_abort();
    test_ovf();
    test_random();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled on a rising edge.
REQ-006 op  input  2  operation select: 00 a+b, 01 a+1, 10 a-b, 11 pass a (a+0).
REQ-007 a  input  WIDTH  operand A; captured when start is accepted.
REQ-008 b  input  WIDTH  operand B; captured when start is accepted, ignored for op 01 and op 11.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking that sum and carry_out are valid.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 carry_out  output  1  carry out of the MSB; for op 10 a value of 1 means no borrow.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded from the state register.
REQ-014 IDLE/DONE with start=1 -> RUN: latch a, the effective B and the carry-in, and clear the digit counter and the partial sum.
REQ-015 Effective B and carry-in per op: 00 -> b, 0; 01 -> 0, 1; 10 -> ~b, 1; 11 -> 0, 0.
REQ-016 RUN: each edge adds one DIGIT-wide slice, LSB slice first, plus the running carry, and stores the slice result; the counter increments by one per edge.
REQ-017 RUN -> DONE on the edge that processes the last slice (N = WIDTH/DIGIT); on that edge sum and carry_out update.
REQ-018 Latency: done SHALL be high exactly N rising edges after the edge that accepted start, for exactly one cycle.
REQ-019 DONE with start=0 -> IDLE; DONE with start=1 accepts the new operation (back-to-back, no idle cycle).
REQ-020 start while in RUN SHALL be ignored; the captured operands are unaffected by changes on a, b and op during RUN.
REQ-021 sum and carry_out SHALL hold their last completed value until the next completion; partial results SHALL never appear on sum.
REQ-022 DIGIT == WIDTH SHALL degenerate to N=1: done is high on the cycle after start is accepted.
REQ-023 All arithmetic is modulo 2^WIDTH; the carry beyond the MSB goes only to carry_out.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, carry_out=0, counter=0, and ovf=0 when ovf is present.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises is handled normally.

Configuration
REQ-026 When macro ADD_SERIAL_OVF_EN is defined, the output ovf (1 bit) SHALL exist and update with sum: two's-complement signed overflow of the completed operation (the carry into the MSB XOR the carry out of the MSB).
REQ-027 When ADD_SERIAL_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour is unchanged.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-028 op=00, a=0000h, b=FFFFh, start for one cycle -> busy high for 4 cycles, done pulses 4 edges after start, sum=FFFFh, carry_out=0.
REQ-029 op=00, a=FFFFh, b=FFFFh -> sum=FFFEh, carry_out=1. Then op=00, a=AAAAh, b=5555h issued in the done cycle -> accepted back-to-back, sum=FFFFh, carry_out=0.
REQ-030 op=01, a=FFFFh -> sum=0000h, carry_out=1. Then op=10, a=0000h, b=0001h -> sum=FFFFh, carry_out=0 (borrow).
REQ-031 Start accepted, start re-asserted and a/b changed during RUN, then rst_n pulsed low on the second RUN cycle -> outputs zero immediately, no done pulse. A following op=00, a=0003h, b=0004h -> sum=0007h.
REQ-032 ADD_SERIAL_OVF_EN defined, op=00, a=7FFFh, b=0001h -> sum=8000h, ovf=1. With WIDTH=16, DIGIT=16, op=10, a=8000h, b=0001h -> done one edge after start, sum=7FFFh, ovf=1.
